text_console: RTL

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console_if.sv | 19 +
 rtl/text_console.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/text_console_if.sv
// Byte-input handshake and character-memory write port of the text console.
interface text_console_if;
  logic [7:0]  tc_data;
  logic        tc_valid;
  logic        tc_ready;
  logic [7:0]  vm_ch_in;
  logic [12:0] vm_ch_addr;
  logic        vm_ch_write_enable;

  modport master (
    output tc_data, tc_valid,
    input  tc_ready, vm_ch_in, vm_ch_addr, vm_ch_write_enable
  );

  modport slave (
    input  tc_data, tc_valid,
    output tc_ready, vm_ch_in, vm_ch_addr, vm_ch_write_enable
  );
endinterface

// File: rtl/text_console.sv
// Character-cell text console: places incoming bytes into a COLS x ROWS character
// memory, handles CR/LF/BS/FF and clears lines or the whole screen with BLANK.
module text_console #(
  parameter int         COLS  = 107,
  parameter int         ROWS  = 40,
  parameter logic [7:0] BLANK = 8'd32
) (
  input  logic         clk,
  input  logic         rst_n,
  text_console_if.slave bus,
  output logic [6:0]   cur_col,
  output logic [5:0]   cur_row,
  output logic         busy
);

  typedef enum logic [1:0] {CLR_ALL, IDLE, WRITE, CLR_LINE} state_t;

  localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
  localparam logic [12:0] LINE     = 13'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  state_t      state, state_d;
  logic [12:0] clr_cnt, clr_cnt_d;
  logic [12:0] row_base, row_base_d;
  logic [6:0]  col_d;
  logic [5:0]  row_d;
  logic        adv, adv_d;
  logic        we_d;
  logic [12:0] addr_d;
  logic [7:0]  ch_d;

  logic        accept;
  logic        row_wrap;
  logic [5:0]  next_row;
  logic [12:0] next_base;
  logic [12:0] cur_addr;

  assign bus.tc_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign accept       = bus.tc_valid && bus.tc_ready;

  // Row base steps by COLS per row and wraps to 0, so no multiplier is needed.
  assign row_wrap  = (cur_row == LAST_ROW);
  assign next_row  = row_wrap ? 6'd0 : cur_row + 6'd1;
  assign next_base = row_wrap ? 13'd0 : row_base + LINE;
  assign cur_addr  = row_base + {6'd0, cur_col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= CLR_ALL;
      clr_cnt                <= 13'd0;
      row_base               <= 13'd0;
      cur_col                <= 7'd0;
      cur_row                <= 6'd0;
      adv                    <= 1'b0;
      bus.vm_ch_write_enable <= 1'b0;
      bus.vm_ch_addr         <= 13'd0;
      bus.vm_ch_in           <= 8'd0;
    end else begin
      state                  <= state_d;
      clr_cnt                <= clr_cnt_d;
      row_base               <= row_base_d;
      cur_col                <= col_d;
      cur_row                <= row_d;
      adv                    <= adv_d;
      bus.vm_ch_write_enable <= we_d;
      bus.vm_ch_addr         <= addr_d;
      bus.vm_ch_in           <= ch_d;
    end
  end

  // The write strobe is registered, so each clear state spends one extra cycle
  // (counter == limit) letting the last strobe drain before returning to IDLE.
  always_comb begin
    state_d    = state;
    clr_cnt_d  = clr_cnt;
    row_base_d = row_base;
    col_d      = cur_col;
    row_d      = cur_row;
    adv_d      = adv;
    we_d       = 1'b0;
    addr_d     = bus.vm_ch_addr;
    ch_d       = bus.vm_ch_in;

    case (state)
      CLR_ALL: begin
        if (clr_cnt == CELLS) begin
          state_d = IDLE;
        end else begin
          we_d      = 1'b1;
          addr_d    = clr_cnt;
          ch_d      = BLANK;
          clr_cnt_d = clr_cnt + 13'd1;
        end
      end

      CLR_LINE: begin
        if (clr_cnt == LINE) begin
          state_d = IDLE;
        end else begin
          we_d      = 1'b1;
          addr_d    = row_base + clr_cnt;
          ch_d      = BLANK;
          clr_cnt_d = clr_cnt + 13'd1;
        end
      end

      IDLE: begin
        if (accept) begin
          case (bus.tc_data)
            8'h0D: col_d = 7'd0;
            8'h0A: begin
              col_d      = 7'd0;
              row_d      = next_row;
              row_base_d = next_base;
              clr_cnt_d  = 13'd0;
              state_d    = CLR_LINE;
            end
            8'h0C: begin
              col_d      = 7'd0;
              row_d      = 6'd0;
              row_base_d = 13'd0;
              clr_cnt_d  = 13'd0;
              state_d    = CLR_ALL;
            end
            8'h08: begin
              if (cur_col != 7'd0) begin
                col_d   = cur_col - 7'd1;
                we_d    = 1'b1;
                addr_d  = cur_addr - 13'd1;
                ch_d    = BLANK;
                adv_d   = 1'b0;
                state_d = WRITE;
              end
            end
            default: begin
              we_d    = 1'b1;
              addr_d  = cur_addr;
              ch_d    = bus.tc_data;
              adv_d   = 1'b1;
              state_d = WRITE;
            end
          endcase
        end
      end

      WRITE: begin
        state_d = IDLE;
        if (adv) begin
          if (cur_col == LAST_COL) begin
            col_d      = 7'd0;
            row_d      = next_row;
            row_base_d = next_base;
            clr_cnt_d  = 13'd0;
            state_d    = CLR_LINE;
          end else begin
            col_d = cur_col + 7'd1;
          end
        end
      end

      default: state_d = CLR_ALL;
    endcase
  end

endmodule
